// File: rtl/mem_1024x8_fifo_ctrl_pkg.sv
// Shared constants for the memory-backed FIFO controller and its output skid buffer.
package mem_1024x8_fifo_ctrl_pkg;

    localparam int unsigned AwDefault        = 10;
    localparam int unsigned DwDefault        = 8;
    localparam int unsigned SkidDepth        = 2;
    localparam int unsigned AlmostFullMargin = 4;

endpackage

// File: rtl/mem_fifo_skid2.sv
// Two-entry output buffer absorbing the one-cycle read latency of the attached memory.
module mem_fifo_skid2
    import mem_1024x8_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DW = DwDefault
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clear_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] entry_q [SkidDepth];
    logic          head_q, head_d;
    logic [1:0]    count_q, count_d;
    logic          wr_idx;

    // Caller never writes while full and never reads while empty.
    always_comb begin
        wr_idx  = head_q ^ count_q[0];
        head_d  = head_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (rd_en_i) begin
                head_d = ~head_q;
            end
            case ({wr_en_i, rd_en_i})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q     <= 1'b0;
            count_q    <= 2'd0;
            entry_q[0] <= '0;
            entry_q[1] <= '0;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
            if (clear_i) begin
                entry_q[0] <= '0;
                entry_q[1] <= '0;
            end else if (wr_en_i) begin
                entry_q[wr_idx] <= wr_data_i;
            end
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign data_o  = entry_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/mem_1024x8_fifo_ctrl.sv
// FIFO controller around an external dual-port memory with a registered-read port.
// Optional MEM_FIFO_CTRL_LEVEL_EN adds the level and almost_full outputs.
module mem_1024x8_fifo_ctrl
    import mem_1024x8_fifo_ctrl_pkg::*;
#(
    parameter int unsigned AW = AwDefault,
    parameter int unsigned DW = DwDefault
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push_valid,
    output logic          push_ready,
    input  logic [DW-1:0] push_data,
    output logic          pop_valid,
    input  logic          pop_ready,
    output logic [DW-1:0] pop_data,
    output logic [AW-1:0] memory_waddr,
    output logic [DW-1:0] memory_data_in,
    output logic          memory_wen,
    output logic [AW-1:0] memory_raddr,
    output logic          memory_ren,
`ifdef MEM_FIFO_CTRL_LEVEL_EN
    output logic [AW:0]   level,
    output logic          almost_full,
`endif
    input  logic [DW-1:0] memory_data_out
);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   mem_count_q, mem_count_d;
    logic          rd_inflight_q, rd_inflight_d;
    logic          push_fire, pop_fire, rd_issue;
    logic [1:0]    skid_count;
    logic [2:0]    skid_occ;

    // A read is only issued if its data is guaranteed a slot in the skid buffer.
    always_comb begin
        push_ready = ~mem_count_q[AW] & ~flush;
        push_fire  = push_valid & push_ready;
        pop_fire   = pop_valid & pop_ready;
        skid_occ   = {1'b0, skid_count} + {2'b00, rd_inflight_q};
        rd_issue   = (mem_count_q != '0) & ~flush &
                     (skid_occ < (3'(SkidDepth) + {2'b00, pop_fire}));
    end

    always_comb begin
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        mem_count_d   = mem_count_q;
        rd_inflight_d = rd_issue;
        if (flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            mem_count_d = '0;
        end else begin
            if (push_fire) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (rd_issue) begin
                rptr_d = rptr_q + AW'(1);
            end
            if (push_fire && !rd_issue) begin
                mem_count_d = mem_count_q + (AW+1)'(1);
            end else if (!push_fire && rd_issue) begin
                mem_count_d = mem_count_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            mem_count_q   <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            mem_count_q   <= mem_count_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    assign memory_wen     = push_fire;
    assign memory_waddr   = wptr_q;
    assign memory_data_in = push_data;
    assign memory_ren     = rd_issue;
    assign memory_raddr   = rptr_q;

    // Flush drops the returning read data by clearing instead of capturing.
    mem_fifo_skid2 #(
        .DW(DW)
    ) u_skid (
        .clk_i    (clk),
        .reset_i  (reset),
        .clear_i  (flush),
        .wr_en_i  (rd_inflight_q),
        .wr_data_i(memory_data_out),
        .rd_en_i  (pop_fire),
        .valid_o  (pop_valid),
        .data_o   (pop_data),
        .count_o  (skid_count)
    );

`ifdef MEM_FIFO_CTRL_LEVEL_EN
    localparam logic [AW:0] AfThresh = (AW+1)'((1 << AW) - AlmostFullMargin);

    logic [AW:0] level_q, level_d;

    // Entries only enter by push and leave by pop, so the total tracks those two events.
    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else begin
            case ({push_fire, pop_fire})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level       = level_q;
    assign almost_full = (mem_count_q >= AfThresh);
`endif

endmodule

// File: tb/tb_mem_1024x8_fifo_ctrl.sv
// Bench for mem_1024x8_fifo_ctrl: behavioural memory, queue scoreboard, vector table, sequences.
module tb_mem_1024x8_fifo_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          flush      = 1'b0;
    logic          push_valid = 1'b0;
    logic [DW-1:0] push_data  = '0;
    logic          pop_ready  = 1'b0;
    logic          push_ready;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic [AW-1:0] memory_waddr;
    logic [DW-1:0] memory_data_in;
    logic          memory_wen;
    logic [AW-1:0] memory_raddr;
    logic          memory_ren;
    logic [DW-1:0] memory_data_out = '0;
`ifdef MEM_FIFO_CTRL_LEVEL_EN
    logic [AW:0]   level;
    logic          almost_full;
`endif

    logic [DW-1:0] mem_model [DEPTH];

    int            checks = 0;
    int            errors = 0;
    int            npop   = 0;
    logic [DW-1:0] exp_q [$];
    logic          stall_q = 1'b0;
    logic [DW-1:0] held_q  = '0;
    logic          last_push_fire = 1'b0;
    logic          last_pop_fire  = 1'b0;

    typedef struct {
        logic          pv;
        logic [DW-1:0] pd;
        logic          pr;
        logic          fl;
        logic          e_prdy;
        logic          e_pvld;
        logic [DW-1:0] e_pdata;
        logic          e_wen;
        logic          e_ren;
    } vec_t;

    vec_t vecs [12];

    mem_1024x8_fifo_ctrl #(
        .AW(AW),
        .DW(DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .push_valid     (push_valid),
        .push_ready     (push_ready),
        .push_data      (push_data),
        .pop_valid      (pop_valid),
        .pop_ready      (pop_ready),
        .pop_data       (pop_data),
        .memory_waddr   (memory_waddr),
        .memory_data_in (memory_data_in),
        .memory_wen     (memory_wen),
        .memory_raddr   (memory_raddr),
        .memory_ren     (memory_ren),
`ifdef MEM_FIFO_CTRL_LEVEL_EN
        .level          (level),
        .almost_full    (almost_full),
`endif
        .memory_data_out(memory_data_out)
    );

    always #5 clk = ~clk;

    // Dual-port memory: write on wen, read data registered one cycle after ren.
    always @(posedge clk) begin
        if (memory_wen) mem_model[memory_waddr] <= memory_data_in;
        if (memory_ren) memory_data_out <= mem_model[memory_raddr];
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    // Apply inputs, then sample 1ns later and update the order scoreboard.
    task automatic drive(input logic pv, input logic [DW-1:0] pd, input logic pr,
                         input logic fl);
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        flush      = fl;
        #1;
        if (stall_q) begin
            chk("stall_valid", npop, 32'(pop_valid), 32'd1);
            chk("stall_data", npop, 32'(pop_data), 32'(held_q));
        end
        last_push_fire = push_valid && push_ready;
        last_pop_fire  = pop_valid && pop_ready;
        if (last_pop_fire) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected[%0d] actual=%0h expected=none", npop, pop_data);
            end else begin
                chk("pop_data", npop, 32'(pop_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            npop++;
        end
        if (last_push_fire) exp_q.push_back(pd);
        if (fl) exp_q.delete();
        stall_q = pop_valid && !pop_ready && !fl;
        held_q  = pop_data;
    endtask

    task automatic step(input logic pv, input logic [DW-1:0] pd, input logic pr,
                        input logic fl);
        drive(pv, pd, pr, fl);
        @(negedge clk);
    endtask

    task automatic do_reset();
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
        reset      = 1'b1;
        exp_q.delete();
        stall_q = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int g = 0; g < 1200; g++) begin
            if (exp_q.size() == 0 && !pop_valid) break;
            step(1'b0, '0, 1'b1, 1'b0);
        end
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        chk(name, 0, 32'(exp_q.size()), 32'd0);
        chk({name, "_valid"}, 0, 32'(pop_valid), 32'd0);
    endtask

    initial begin
        int accepted;
        int cycles;

        //          pv    pd     pr    fl    prdy  pvld  pdata  wen   ren
        vecs[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

        // Outputs while reset is held
        #2;
        chk("rst_pop_valid", 0, 32'(pop_valid), 32'd0);
        chk("rst_pop_data", 0, 32'(pop_data), 32'd0);
        chk("rst_wen", 0, 32'(memory_wen), 32'd0);
        chk("rst_ren", 0, 32'(memory_ren), 32'd0);
        chk("rst_waddr", 0, 32'(memory_waddr), 32'd0);
        chk("rst_raddr", 0, 32'(memory_raddr), 32'd0);
        chk("rst_push_ready", 0, 32'(push_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Three-entry latency/order run followed by a flush with a read in flight
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].pv, vecs[i].pd, vecs[i].pr, vecs[i].fl);
            chk("vec_push_ready", i, 32'(push_ready), 32'(vecs[i].e_prdy));
            chk("vec_pop_valid", i, 32'(pop_valid), 32'(vecs[i].e_pvld));
            if (vecs[i].e_pvld) chk("vec_pop_data", i, 32'(pop_data), 32'(vecs[i].e_pdata));
            chk("vec_wen", i, 32'(memory_wen), 32'(vecs[i].e_wen));
            chk("vec_ren", i, 32'(memory_ren), 32'(vecs[i].e_ren));
            @(negedge clk);
        end

        // Asynchronous reset with a read in flight
        do_reset();
        step(1'b1, 8'hA1, 1'b0, 1'b0);
        step(1'b1, 8'hA2, 1'b0, 1'b0);
        push_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_pop_valid", 0, 32'(pop_valid), 32'd0);
        chk("mid_rst_pop_data", 0, 32'(pop_data), 32'd0);
        chk("mid_rst_ren", 0, 32'(memory_ren), 32'd0);
        chk("mid_rst_raddr", 0, 32'(memory_raddr), 32'd0);
        chk("mid_rst_waddr", 0, 32'(memory_waddr), 32'd0);
        chk("mid_rst_push_ready", 0, 32'(push_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        stall_q = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            chk("post_rst_pop_valid", k, 32'(pop_valid), 32'd0);
            @(negedge clk);
        end

        // Fill with the consumer stalled: memory plus two buffered entries
        do_reset();
        accepted = 0;
        for (int g = 0; g < 1100; g++) begin
            drive(1'b1, accepted[7:0], 1'b0, 1'b0);
            @(negedge clk);
            if (!last_push_fire) break;
            accepted++;
`ifdef MEM_FIFO_CTRL_LEVEL_EN
            if (accepted == DEPTH - 3) chk("level_1021", 0, 32'(level), 32'(DEPTH - 3));
`endif
        end
        chk("capacity", 0, 32'(accepted), 32'(DEPTH + 2));
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("pop_at_full", 0, 32'(last_pop_fire), 32'd1);
        @(negedge clk);
        drive(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ready_after_pop", 0, 32'(push_ready), 32'd1);
        @(negedge clk);
        drain("full_drain");

        // 1500 entries streamed with continuous pops; pointers wrap
        accepted = 0;
        cycles   = 0;
        for (int g = 0; g < 1600 && accepted < 1500; g++) begin
            step(1'b1, 8'(accepted % 256), 1'b1, 1'b0);
            cycles++;
            if (last_push_fire) accepted++;
        end
        chk("wrap_pushed", 0, 32'(accepted), 32'd1500);
        chk("throughput", 0, 32'(cycles), 32'd1500);
        drain("wrap_drain");

        // Random traffic with stalls and occasional flushes
        for (int g = 0; g < 3000; g++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 63) == 0));
        end
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
